sdram_read: RTL and testbench

SDRAM_READ -- requirements
Module: sdram_read

---
 rtl/sdram_read_pkg.sv | 45 ++++
 rtl/sdram_read_capture.sv | 45 ++++
 rtl/sdram_read.sv | 162 ++++++++++++++++
 tb/tb_sdram_read.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_read_pkg.sv
// Shared SDRAM definitions: command encodings, timing defaults, address fields, read FSM states.
// SDRAM_READ_CAS3_EN selects CAS latency 3; otherwise CAS latency is 2.
package sdram_read_pkg;

  typedef enum logic [2:0] {
    CMD_LMR   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_TERM  = 3'b110,
    CMD_NOP   = 3'b111
  } sdram_cmd_t;

  localparam int unsigned T_RCD_CYC_DEF = 3;
  localparam int unsigned T_RP_CYC_DEF  = 3;
`ifdef SDRAM_READ_CAS3_EN
  localparam int unsigned CAS_LATENCY   = 3;
`else
  localparam int unsigned CAS_LATENCY   = 2;
`endif

  localparam int unsigned BANK_W = 2;
  localparam int unsigned ROW_W  = 12;
  localparam int unsigned COL_W  = 8;
  localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int unsigned DQ_W   = 16;
  localparam int unsigned DQM_W  = 2;
  localparam int unsigned CNT_W  = 24;
  localparam int unsigned DLY_W  = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACTIVATE,
    ST_READ_COMMAND,
    ST_READ_TOP,
    ST_READ_BOTTOM,
    ST_BURST_TERMINATE,
    ST_PRECHARGE,
    ST_DRAIN
  } rd_state_t;

endpackage

// File: rtl/sdram_read_capture.sv
// Read-beat capture: CL-deep wanted-tag pipeline aligned to DQ, pairs beats into 32-bit FIFO words.
module sdram_read_capture
  import sdram_read_pkg::*;
#(
  parameter int unsigned CL = CAS_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_tag,
  input  logic [DQ_W-1:0]   data_in,
  output logic [2*DQ_W-1:0] fifo_data,
  output logic              fifo_write,
  output logic              busy
);

  logic [CL-1:0]   tag_pipe;
  logic            have_upper;
  logic [DQ_W-1:0] upper;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_pipe   <= '0;
      have_upper <= 1'b0;
      upper      <= '0;
      fifo_data  <= '0;
      fifo_write <= 1'b0;
    end else begin
      tag_pipe   <= {tag_pipe[CL-2:0], beat_tag};
      fifo_write <= 1'b0;
      if (tag_pipe[CL-1]) begin
        if (!have_upper) begin
          upper      <= data_in;
          have_upper <= 1'b1;
        end else begin
          fifo_data  <= {upper, data_in};
          fifo_write <= 1'b1;
          have_upper <= 1'b0;
        end
      end
    end
  end

  assign busy = beat_tag | (|tag_pipe) | have_upper;

endmodule

// File: rtl/sdram_read.sv
// SDRAM full-page read path: activates a row, streams beats into a FIFO, splits at row end or refresh.
// Build with SDRAM_READ_CAS3_EN for CAS latency 3 (default 2).
module sdram_read
  import sdram_read_pkg::*;
#(
  parameter int unsigned T_RCD_CYC = T_RCD_CYC_DEF,
  parameter int unsigned T_RP_CYC  = T_RP_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [2:0]            command,
  output logic [ROW_W-1:0]      address,
  output logic [BANK_W-1:0]     bank,
  input  logic [DQ_W-1:0]       data_in,
  output logic [DQM_W-1:0]      data_mask,
  output logic                  idle,
  input  logic                  enable,
  input  logic [ADDR_W-1:0]     app_address,
  input  logic                  auto_refresh,
  output logic                  wait_for_refresh,
  output logic [2*DQ_W-1:0]     fifo_data,
  output logic                  fifo_write,
  input  logic                  fifo_ready,
  output logic                  fifo_activate,
  input  logic [CNT_W-1:0]      fifo_size
);

  rd_state_t         state, state_n;
  sdram_cmd_t        command_n;
  logic [ROW_W-1:0]  address_n;
  logic [BANK_W-1:0] bank_n;
  logic [DLY_W-1:0]  delay, delay_n;
  logic [ADDR_W-1:0] read_address, read_address_n, ra_inc;
  logic [CNT_W-1:0]  word_count, count_n, count_inc;
  logic              fifo_activate_n, wfr_n;
  logic              beat_tag, tag_n, busy;

  assign ra_inc    = read_address + 22'd2;
  assign count_inc = word_count + 1'b1;
  assign data_mask = '0;
  assign idle      = (delay == '0) && (state == ST_IDLE || state == ST_WAIT) && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      command          <= CMD_NOP;
      address          <= '0;
      bank             <= '0;
      delay            <= '0;
      read_address     <= '0;
      word_count       <= '0;
      fifo_activate    <= 1'b0;
      wait_for_refresh <= 1'b0;
      beat_tag         <= 1'b0;
    end else begin
      state            <= state_n;
      command          <= command_n;
      address          <= address_n;
      bank             <= bank_n;
      delay            <= delay_n;
      read_address     <= read_address_n;
      word_count       <= count_n;
      fifo_activate    <= fifo_activate_n;
      wait_for_refresh <= wfr_n;
      beat_tag         <= tag_n;
    end
  end

  always_comb begin
    state_n         = state;
    command_n       = CMD_NOP;
    address_n       = address;
    bank_n          = bank;
    delay_n         = delay;
    read_address_n  = read_address;
    count_n         = word_count;
    fifo_activate_n = fifo_activate;
    wfr_n           = 1'b0;
    tag_n           = 1'b0;
    if (delay != '0) begin
      delay_n = delay - 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          wfr_n = 1'b1;
          if (enable || fifo_ready) begin
            read_address_n = app_address;
            state_n        = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (auto_refresh) begin
            wfr_n = 1'b1;
          end else if (!fifo_activate) begin
            if (fifo_ready) begin
              fifo_activate_n = 1'b1;
              count_n         = '0;
            end else if (!enable) begin
              state_n = ST_IDLE;
            end
          end else if (word_count < fifo_size) begin
            state_n = ST_ACTIVATE;
          end else begin
            fifo_activate_n = 1'b0;
            delay_n         = DLY_W'(1);
          end
        end
        ST_ACTIVATE: begin
          command_n = CMD_ACT;
          bank_n    = read_address[ADDR_W-1 -: BANK_W];
          address_n = read_address[COL_W +: ROW_W];
          delay_n   = DLY_W'(T_RCD_CYC);
          state_n   = ST_READ_COMMAND;
        end
        ST_READ_COMMAND: begin
          command_n = CMD_READ;
          address_n = {4'b0, read_address[COL_W-1:0]};
          tag_n     = 1'b1;
          state_n   = ST_READ_BOTTOM;
        end
        ST_READ_TOP: begin
          tag_n   = 1'b1;
          state_n = ST_READ_BOTTOM;
        end
        // Bottom beat closes a word, so a split here never leaves half a word behind.
        ST_READ_BOTTOM: begin
          tag_n          = 1'b1;
          read_address_n = ra_inc;
          count_n        = count_inc;
          if (ra_inc[COL_W-1:0] == '0 || auto_refresh || count_inc == fifo_size)
            state_n = ST_BURST_TERMINATE;
          else
            state_n = ST_READ_TOP;
        end
        ST_BURST_TERMINATE: begin
          command_n = CMD_TERM;
          state_n   = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!busy) state_n = ST_PRECHARGE;
        end
        ST_PRECHARGE: begin
          command_n = CMD_PRE;
          delay_n   = DLY_W'(T_RP_CYC);
          state_n   = ST_WAIT;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  sdram_read_capture #(.CL(CAS_LATENCY)) u_capture (
    .clk        (clk),
    .rst        (rst),
    .beat_tag   (beat_tag),
    .data_in    (data_in),
    .fifo_data  (fifo_data),
    .fifo_write (fifo_write),
    .busy       (busy)
  );

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read with a behavioural full-page-burst SDRAM and FIFO recorder.
module tb_sdram_read;

`ifdef SDRAM_READ_CAS3_EN
  localparam int CL = 3;
`else
  localparam int CL = 2;
`endif
  localparam logic [2:0] C_NOP  = 3'b111;
  localparam logic [2:0] C_ACT  = 3'b011;
  localparam logic [2:0] C_READ = 3'b101;
  localparam logic [2:0] C_TERM = 3'b110;
  localparam logic [2:0] C_PRE  = 3'b010;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  command;
  logic [11:0] address;
  logic [1:0]  bank;
  logic [15:0] data_in;
  logic [1:0]  data_mask;
  logic        idle, enable, auto_refresh, wait_for_refresh;
  logic [21:0] app_address;
  logic [31:0] fifo_data;
  logic        fifo_write, fifo_ready, fifo_activate;
  logic [23:0] fifo_size;

  int vectors = 0;
  int miscompares = 0;

  sdram_read #(.T_RCD_CYC(3), .T_RP_CYC(3)) dut (
    .clk(clk), .rst(rst), .command(command), .address(address), .bank(bank),
    .data_in(data_in), .data_mask(data_mask), .idle(idle), .enable(enable),
    .app_address(app_address), .auto_refresh(auto_refresh),
    .wait_for_refresh(wait_for_refresh), .fifo_data(fifo_data),
    .fifo_write(fifo_write), .fifo_ready(fifo_ready),
    .fifo_activate(fifo_activate), .fifo_size(fifo_size)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] beat_val(input logic [21:0] a);
    return a[15:0] ^ 16'hA500 ^ {14'd0, a[21:20]};
  endfunction

  // SDRAM model and recorder; command seen here is sampled by the device at the next rising edge.
  logic [11:0] open_row [4];
  logic [15:0] dpipe [CL];
  logic        burst_on = 1'b0;
  logic [1:0]  b_bank;
  logic [7:0]  b_col;
  int          cyc = 0;
  logic [31:0] wq[$];
  int          wr_cyc[$];
  int          rd_cyc[$];
  logic [11:0] rd_q[$];
  logic [13:0] act_q[$];
  int          term_cnt = 0, pre_cnt = 0, fa_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    data_in = dpipe[CL-1];
    for (int i = CL-1; i > 0; i--) dpipe[i] = dpipe[i-1];
    case (command)
      C_ACT:  begin open_row[bank] = address; act_q.push_back({bank, address}); end
      C_READ: begin burst_on = 1'b1; b_bank = bank; b_col = address[7:0];
                    rd_q.push_back(address); rd_cyc.push_back(cyc); end
      C_TERM: begin burst_on = 1'b0; term_cnt++; end
      C_PRE:  begin burst_on = 1'b0; pre_cnt++; end
      default: ;
    endcase
    if (burst_on) begin
      dpipe[0] = beat_val({b_bank, open_row[b_bank], b_col});
      b_col++;
    end else begin
      dpipe[0] = 16'hDEAD;
    end
    if (fifo_write) begin wq.push_back(fifo_data); wr_cyc.push_back(cyc); end
    if (fifo_activate) fa_cyc++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(input logic [21:0] a, input logic [23:0] sz, output bit ok);
    app_address = a; fifo_size = sz; enable = 1'b1; fifo_ready = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (fifo_activate) ok = 1'b1;
    end
    enable = 1'b0; fifo_ready = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int run = 0;
    for (int i = 0; i < budget && run < 3; i++) begin
      tick();
      if (!fifo_activate && idle && wait_for_refresh) run++; else run = 0;
    end
    ok = (run >= 3);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; fifo_ready = 1'b0; auto_refresh = 1'b0;
    app_address = '0; fifo_size = '0;
    repeat (3) tick();
    vectors++; if (command !== C_NOP) begin miscompares++; $display("FAIL reset_command got %b want %b", command, C_NOP); end
    vectors++; if ({bank, address} !== 14'd0) begin miscompares++; $display("FAIL reset_bank_addr got %h want 0", {bank, address}); end
    vectors++; if (data_mask !== 2'd0) begin miscompares++; $display("FAIL reset_dqm got %b want 00", data_mask); end
    vectors++; if (fifo_data !== 32'd0) begin miscompares++; $display("FAIL reset_fifo_data got %h want 0", fifo_data); end
    vectors++; if ({fifo_write, fifo_activate, wait_for_refresh} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes got %b want 000", {fifo_write, fifo_activate, wait_for_refresh}); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle got %b want 1", idle); end
    rst = 1'b0;
    repeat (2) tick();
    vectors++; if (wait_for_refresh !== 1'b1) begin miscompares++; $display("FAIL idle_wfr got %b want 1", wait_for_refresh); end
  endtask

  task automatic test_base_read();
    int wb = wq.size(), ab = act_q.size(), rb = rd_q.size(), tb0 = term_cnt, pb = pre_cnt, n;
    bit ok;
    logic [21:0] ea;
    launch(22'h000010, 24'd4, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL base_launch got 0 want 1"); end
    wait_quiet(400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL base_timeout got 0 want 1"); end
    n = wq.size() - wb;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL base_words got %0d want 4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      ea = 22'h000010 + 22'(2*k);
      vectors++;
      if (wq[wb+k] !== {beat_val(ea), beat_val(ea + 22'd1)}) begin
        miscompares++; $display("FAIL base_word%0d got %h want %h", k, wq[wb+k], {beat_val(ea), beat_val(ea + 22'd1)});
      end
    end
    vectors++; if (act_q.size() - ab !== 1 || act_q[ab] !== 14'h0000) begin miscompares++; $display("FAIL base_act got n=%0d want 1 at row 0", act_q.size() - ab); end
    vectors++; if (rd_q.size() - rb !== 1 || rd_q[rb] !== 12'h010) begin miscompares++; $display("FAIL base_read_col got n=%0d want 1 at col 010", rd_q.size() - rb); end
    if (n > 0 && rd_cyc.size() > rb) begin
      vectors++;
      if (wr_cyc[wb] - rd_cyc[rb] !== CL + 2) begin
        miscompares++; $display("FAIL base_latency got %0d want %0d", wr_cyc[wb] - rd_cyc[rb], CL + 2);
      end
    end
    vectors++; if (term_cnt - tb0 !== 1 || pre_cnt - pb !== 1) begin miscompares++; $display("FAIL base_term_pre got %0d/%0d want 1/1", term_cnt - tb0, pre_cnt - pb); end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL base_idle got %b want 1", idle); end
  endtask

  task automatic test_row_boundary();
    int wb = wq.size(), ab = act_q.size(), rb = rd_q.size(), tb0 = term_cnt, n;
    bit ok;
    logic [21:0] ea;
    launch(22'h0000FC, 24'd4, ok);
    wait_quiet(400, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL row_timeout got 0 want 1"); end
    n = wq.size() - wb;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL row_words got %0d want 4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      ea = 22'h0000FC + 22'(2*k);
      vectors++;
      if (wq[wb+k] !== {beat_val(ea), beat_val(ea + 22'd1)}) begin
        miscompares++; $display("FAIL row_word%0d got %h want %h", k, wq[wb+k], {beat_val(ea), beat_val(ea + 22'd1)});
      end
    end
    vectors++;
    if (act_q.size() - ab !== 2 || act_q[ab] !== 14'h0000 || act_q[ab+1] !== 14'h0001) begin
      miscompares++; $display("FAIL row_acts got n=%0d want rows 0 then 1", act_q.size() - ab);
    end
    vectors++;
    if (rd_q.size() - rb !== 2 || rd_q[rb] !== 12'h0FC || rd_q[rb+1] !== 12'h000) begin
      miscompares++; $display("FAIL row_reads got n=%0d want cols 0FC then 000", rd_q.size() - rb);
    end
    vectors++; if (term_cnt - tb0 !== 2) begin miscompares++; $display("FAIL row_terms got %0d want 2", term_cnt - tb0); end
  endtask

  task automatic test_refresh();
    int wb = wq.size(), ab = act_q.size(), rb = rd_q.size(), n, mid = 0;
    bit ok, seen = 1'b0;
    logic [21:0] ea;
    launch(22'h200200, 24'd8, ok);
    for (int i = 0; i < 300 && wq.size() == wb; i++) tick();
    auto_refresh = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (wait_for_refresh && fifo_activate) seen = 1'b1;
    end
    mid = wq.size() - wb;
    repeat (5) tick();
    auto_refresh = 1'b0;
    wait_quiet(600, ok);
    vectors++; if (!seen) begin miscompares++; $display("FAIL ref_wfr got 0 want 1"); end
    vectors++; if (!(mid >= 1 && mid < 8)) begin miscompares++; $display("FAIL ref_split got %0d want 1..7", mid); end
    vectors++; if (!ok) begin miscompares++; $display("FAIL ref_timeout got 0 want 1"); end
    n = wq.size() - wb;
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL ref_words got %0d want 8", n); end
    for (int k = 0; k < 8 && k < n; k++) begin
      ea = 22'h200200 + 22'(2*k);
      vectors++;
      if (wq[wb+k] !== {beat_val(ea), beat_val(ea + 22'd1)}) begin
        miscompares++; $display("FAIL ref_word%0d got %h want %h", k, wq[wb+k], {beat_val(ea), beat_val(ea + 22'd1)});
      end
    end
    vectors++;
    if (act_q.size() - ab !== 2 || act_q[ab+1] !== {2'd2, 12'h002}) begin
      miscompares++; $display("FAIL ref_acts got n=%0d want 2 at bank 2 row 2", act_q.size() - ab);
    end
    vectors++;
    if (rd_q.size() - rb !== 2 || rd_q[rb+1] !== {4'd0, 8'(2*mid)}) begin
      miscompares++; $display("FAIL ref_resume_col got n=%0d want 2 reads resuming at %0h", rd_q.size() - rb, 2*mid);
    end
  endtask

  task automatic test_reset_in_drain();
    int wb = wq.size(), n0;
    bit ok, found = 1'b0;
    logic [21:0] ea;
    launch(22'h000040, 24'd4, ok);
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (command === C_TERM) found = 1'b1;
    end
    rst = 1'b1;
    n0 = wq.size();
    vectors++; if (!found) begin miscompares++; $display("FAIL drain_term got 0 want 1"); end
    repeat (3) tick();
    vectors++;
    if ({command, bank, address, fifo_write, fifo_activate, wait_for_refresh} !== {C_NOP, 14'd0, 3'b000}) begin
      miscompares++; $display("FAIL drain_rst_outputs got %h want %h", {command, bank, address, fifo_write, fifo_activate, wait_for_refresh}, {C_NOP, 14'd0, 3'b000});
    end
    rst = 1'b0;
    repeat (10) tick();
    vectors++; if (wq.size() !== n0) begin miscompares++; $display("FAIL drain_no_write got %0d want %0d", wq.size(), n0); end
    vectors++; if (n0 - wb >= 4) begin miscompares++; $display("FAIL drain_abandon got %0d want <4", n0 - wb); end
    for (int k = 0; k < n0 - wb; k++) begin
      ea = 22'h000040 + 22'(2*k);
      vectors++;
      if (wq[wb+k] !== {beat_val(ea), beat_val(ea + 22'd1)}) begin
        miscompares++; $display("FAIL drain_word%0d got %h want %h", k, wq[wb+k], {beat_val(ea), beat_val(ea + 22'd1)});
      end
    end
    vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL drain_idle got %b want 1", idle); end
  endtask

  task automatic test_empty_fifo();
    int ab = act_q.size(), fb = fa_cyc, wb = wq.size();
    bit ok;
    launch(22'h000080, 24'd0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL empty_activate got 0 want 1"); end
    wait_quiet(60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL empty_return_idle got 0 want 1"); end
    vectors++; if (act_q.size() - ab !== 0) begin miscompares++; $display("FAIL empty_no_act got %0d want 0", act_q.size() - ab); end
    vectors++; if (fa_cyc - fb !== 1) begin miscompares++; $display("FAIL empty_fa_pulse got %0d want 1", fa_cyc - fb); end
    vectors++; if (wq.size() - wb !== 0) begin miscompares++; $display("FAIL empty_no_write got %0d want 0", wq.size() - wb); end
  endtask

  initial begin
    test_reset();
    test_base_read();
    test_row_boundary();
    test_refresh();
    test_reset_in_drain();
    test_empty_fifo();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
